matmul_engine: RTL
==================

# matmul_engine

Parametrised hardware matrix-multiply engine. It computes C = A × B directly against the 8-bit-style data memory, replacing the software multiply loop the processor runs through X/Y/Z, STXY/STYZ/STXZ and the AC/ALU path. It generalises operand width, accumulator width, address width and dimension range, and adds a start/busy/done/error handshake. It sits beside the processor as a second data-memory master; arbitration between the two is outside this block.

## Interface
Parameters:
- DATA_W, default 8: element width of A and B; also the memory data width.
- ACC_W, default 24: accumulator and C-element width. Must be a multiple of DATA_W. BYTES = ACC_W/DATA_W.
- ADDR_W, default 16: memory address width.
- DIM_W, default 8: width of each dimension input.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; accepted only in IDLE.
- dim_x, dim_y, dim_z  in  DIM_W each  dimensions: A is X×Y, B is Y×Z, C is X×Z.
- base_a, base_b, base_c  in  ADDR_W each  base addresses of A, B and C.
- mem_rdata  in  DATA_W  read data; valid the cycle after a read is issued.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable; meaningful only while mem_en=1.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  DATA_W  write data.
- busy  out  1  high while the engine owns memory.
- done  out  1  one-cycle pulse when C is complete.
- error  out  1  one-cycle pulse when start is rejected because a dimension is 0.

## Operation
- Layout: all matrices are row-major, unsigned.
  - A[i][k] is at base_a + i·Y + k.
  - B[k][j] is at base_b + k·Z + j.
  - C[i][j] occupies BYTES consecutive bytes, little-endian, starting at base_c + (i·Z + j)·BYTES.
- Address generation uses running pointers only; no address multipliers. All address arithmetic wraps modulo 2^ADDR_W.
- Start acceptance: dims and bases are captured into internal registers on the edge that accepts start. Later input changes have no effect until the next acceptance.
- Loop order: i outer, j middle, k inner. The accumulator clears before each (i, j).
- FSM states: IDLE, RD_A, RD_B, MAC, WR, DONE, ERR.
  - IDLE: start with any captured dim = 0 → ERR. start with all dims nonzero → RD_A.
  - RD_A: issue read of A[i][k] → RD_B.
  - RD_B: capture mem_rdata as a; issue read of B[k][j] → MAC.
  - MAC: acc ← acc + a·mem_rdata. If k < Y−1 → RD_A with k+1; otherwise → WR with byte index 0.
  - WR: write byte b of acc, i.e. acc[DATA_W·b +: DATA_W]. Advance b, then j, then i. After the final byte of C[X−1][Z−1] → DONE.
  - DONE: done=1 → IDLE.
  - ERR: error=1 → IDLE. No memory access is made.
- Arithmetic:
  - The product is 2·DATA_W bits, zero-extended.
  - Accumulation is modulo 2^ACC_W; overflow wraps silently.
  - With default parameters the maximum dimension is 255.
- Output decode:
  - mem_en=1 in RD_A, RD_B and WR.
  - mem_we=1 only in WR.
  - busy=1 in RD_A, RD_B, MAC and WR.
  - In all other states, mem_addr, mem_wdata and mem_we are 0.
- start is ignored in every state except IDLE. A pending start is not queued.

## Timing
- Reset values: every output is 0 and the state is IDLE. The accumulator, pointers and counters are all 0.
- Reset is asynchronous: mem_en, mem_we and busy drop in the same cycle rst rises, whatever the state.
- Acceptance: start is high at edge t in IDLE. From t+1 the state is RD_A with busy=1, mem_en=1 and mem_addr=base_a.
- Read latency is exactly 1 cycle. Data for an address issued in cycle n is sampled in cycle n+1.
- Busy duration: busy stays high for exactly X·Z·(3·Y + BYTES) cycles.
- done is high for the single cycle following the last WR cycle. busy is 0 in that cycle.
- A start in the DONE cycle is ignored. A start one cycle later, in IDLE, is accepted.
- error is high in the cycle after the rejected start. busy stays 0 throughout.
- Reset mid-operation: memory contents already written stay as they are. The next start runs from scratch.

## Test plan
- Reset check: assert rst mid-cycle → all outputs read 0 in the same cycle; release rst, hold start=0 → outputs stay 0 indefinitely.
- 2×2×2 run with defaults:
  - Setup: A=[1,2;3,4] at 0x0010, B=[5,6;7,8] at 0x0020, base_c=0x0040.
  - Expected: bytes 0x40..0x4B = 13 00 00 16 00 00 2B 00 00 32 00 00; busy high for 36 cycles; done a single pulse.
- Width and wrap:
  - Setup: X=Z=1, Y=3, all A and B elements 0xFF.
  - ACC_W=24 → C bytes 03 FA 02 (0x02FA03).
  - ACC_W=16 → C bytes 03 FA (0xFA03, wrapped).
- Zero dimension: start with dim_y=0 → error pulse at t+1; mem_en never asserts; busy stays 0; done stays 0.
- Ignored inputs: during the 2×2×2 run, pulse start and change dim_x to 5 and base_c to 0x0100 → the result and 36-cycle busy are unchanged; nothing is written at or above 0x0100.
- Reset mid-operation: assert rst in busy cycle 10 → mem_en=0 immediately; release and restart the 2×2×2 run → the full correct C is produced in 36 cycles.

Source files
------------

// File: rtl/matmul_engine.sv
// matmul_engine: computes C = A x B by walking the data memory directly.
//   A is X x Y, B is Y x Z, C is X x Z; all row-major and unsigned.
//   A and B elements are DATA_W wide. Each C element is written as
//   BYTES = ACC_W/DATA_W little-endian memory words.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   start               request, accepted only while idle
//   dim_x/y/z           matrix dimensions (DIM_W each)
//   base_a/b/c          base addresses (ADDR_W each)
//   mem_rdata           read data, valid the cycle after the read is issued
//   mem_en/we/addr/wdata  memory master port
//   busy                engine owns memory
//   done                one-cycle pulse when C is complete
//   error               one-cycle pulse when start is rejected (zero dimension)
module matmul_engine #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  dim_x,
    input  logic [DIM_W-1:0]  dim_y,
    input  logic [DIM_W-1:0]  dim_z,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_c,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int BYTES = ACC_W / DATA_W;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_A, S_RD_B, S_MAC, S_WR, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [DIM_W-1:0]  dx_q, dx_d, dy_q, dy_d, dz_q, dz_d;
    logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
    logic [BW-1:0]     b_q, b_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] a_q, a_d;
    // Running pointers:
    //   row_a: start of A row i      ptr_a: A[i][k]
    //   col_b: start of B column j   ptr_b: B[k][j]
    //   ptr_c: next C byte to write
    logic [ADDR_W-1:0] base_b_q, base_b_d;
    logic [ADDR_W-1:0] row_a_q, row_a_d, ptr_a_q, ptr_a_d;
    logic [ADDR_W-1:0] col_b_q, col_b_d, ptr_b_q, ptr_b_d;
    logic [ADDR_W-1:0] ptr_c_q, ptr_c_d;

    logic [2*DATA_W-1:0] prod;
    logic                k_last, j_last, i_last, b_last;

    assign prod   = a_q * mem_rdata;
    assign k_last = (k_q == dy_q - DIM_W'(1));
    assign j_last = (j_q == dz_q - DIM_W'(1));
    assign i_last = (i_q == dx_q - DIM_W'(1));
    assign b_last = (b_q == BW'(BYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            dx_q     <= '0;
            dy_q     <= '0;
            dz_q     <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            base_b_q <= '0;
            row_a_q  <= '0;
            ptr_a_q  <= '0;
            col_b_q  <= '0;
            ptr_b_q  <= '0;
            ptr_c_q  <= '0;
        end else begin
            state_q  <= state_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            dz_q     <= dz_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            base_b_q <= base_b_d;
            row_a_q  <= row_a_d;
            ptr_a_q  <= ptr_a_d;
            col_b_q  <= col_b_d;
            ptr_b_q  <= ptr_b_d;
            ptr_c_q  <= ptr_c_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        dz_d      = dz_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        b_d       = b_q;
        acc_d     = acc_q;
        a_d       = a_q;
        base_b_d  = base_b_q;
        row_a_d   = row_a_q;
        ptr_a_d   = ptr_a_q;
        col_b_d   = col_b_q;
        ptr_b_d   = ptr_b_q;
        ptr_c_d   = ptr_c_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dx_d     = dim_x;
                    dy_d     = dim_y;
                    dz_d     = dim_z;
                    base_b_d = base_b;
                    row_a_d  = base_a;
                    ptr_a_d  = base_a;
                    col_b_d  = base_b;
                    ptr_b_d  = base_b;
                    ptr_c_d  = base_c;
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    b_d      = '0;
                    acc_d    = '0;
                    if (dim_x == '0 || dim_y == '0 || dim_z == '0)
                        state_d = S_ERR;
                    else
                        state_d = S_RD_A;
                end
            end
            S_RD_A: begin
                busy     = 1'b1;
                mem_en   = 1'b1;
                mem_addr = ptr_a_q;
                state_d  = S_RD_B;
            end
            S_RD_B: begin
                // mem_rdata here is the A element requested in RD_A
                busy     = 1'b1;
                mem_en   = 1'b1;
                mem_addr = ptr_b_q;
                a_d      = mem_rdata;
                state_d  = S_MAC;
            end
            S_MAC: begin
                busy  = 1'b1;
                acc_d = acc_q + ACC_W'(prod);
                if (k_last) begin
                    b_d     = '0;
                    state_d = S_WR;
                end else begin
                    k_d     = k_q + DIM_W'(1);
                    ptr_a_d = ptr_a_q + ADDR_W'(1);
                    ptr_b_d = ptr_b_q + ADDR_W'(dz_q);
                    state_d = S_RD_A;
                end
            end
            S_WR: begin
                busy      = 1'b1;
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = ptr_c_q;
                mem_wdata = acc_q[DATA_W*b_q +: DATA_W];
                ptr_c_d   = ptr_c_q + ADDR_W'(1);
                if (!b_last) begin
                    b_d = b_q + BW'(1);
                end else begin
                    // element done: clear for the next (i, j) and step j, then i
                    b_d     = '0;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = S_RD_A;
                    if (!j_last) begin
                        j_d     = j_q + DIM_W'(1);
                        col_b_d = col_b_q + ADDR_W'(1);
                        ptr_b_d = col_b_q + ADDR_W'(1);
                        ptr_a_d = row_a_q;
                    end else begin
                        j_d     = '0;
                        col_b_d = base_b_q;
                        ptr_b_d = base_b_q;
                        if (!i_last) begin
                            i_d     = i_q + DIM_W'(1);
                            row_a_d = row_a_q + ADDR_W'(dy_q);
                            ptr_a_d = row_a_q + ADDR_W'(dy_q);
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                error   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
